// File: rtl/cleared_ram_2r1w_pkg.sv
// Shared types and helpers for the cleared 2-read/1-write register-file RAM.
package cleared_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int ADDRESS_BUS_WIDTH = 6;
    localparam int DEPTH             = 1 << ADDRESS_BUS_WIDTH;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/cleared_ram_2r1w_if.sv
// Bus bundle for the cleared RAM: one write port, two read ports, clear request.
interface cleared_ram_if #(
    parameter int BITS = 64,
    parameter int AW   = 6
);
    logic [BITS-1:0] D;
    logic [AW-1:0]   WAddress;
    logic            WE;
    logic [AW-1:0]   RAddressA;
    logic            REA;
    logic [BITS-1:0] QA;
    logic            QAValid;
    logic [AW-1:0]   RAddressB;
    logic            REB;
    logic [BITS-1:0] QB;
    logic            QBValid;
    logic            CLR;
    logic            Busy;

    modport master (
        output D, WAddress, WE, RAddressA, REA, RAddressB, REB, CLR,
        input  QA, QAValid, QB, QBValid, Busy
    );

    modport slave (
        input  D, WAddress, WE, RAddressA, REA, RAddressB, REB, CLR,
        output QA, QAValid, QB, QBValid, Busy
    );
endinterface

// File: rtl/cleared_ram_2r1w_read_port.sv
// One registered read port with write-first bypass; holds its data while idle or busy.
module ram_read_port #(
    parameter int BITS = 64,
    parameter int AW   = 6
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            Busy,
    input  logic [AW-1:0]   Addr,
    input  logic            RE,
    input  logic            WE,
    input  logic [AW-1:0]   WAddress,
    input  logic [BITS-1:0] D,
    input  logic [BITS-1:0] Word,
    output logic [BITS-1:0] Q,
    output logic            QValid
);

    logic [BITS-1:0] q_q, q_d;
    logic            valid_q, valid_d;

    // Next read data: new word on a request, write data when the same address is written.
    always_comb begin
        q_d     = q_q;
        valid_d = 1'b0;
        if (!Busy && RE) begin
            valid_d = 1'b1;
            q_d     = (WE && (WAddress == Addr)) ? D : Word;
        end
    end

    // Output register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign Q      = q_q;
    assign QValid = valid_q;

endmodule

// File: rtl/cleared_ram_2r1w.sv
// Register-file RAM with two registered read ports and a full-array clear sweep.
module cleared_ram_2r1w
    import cleared_ram_pkg::*;
#(
    parameter int BITS              = 64,
    parameter int ADDRESS_BUS_WIDTH = 6,
    parameter bit CLEAR_ON_RESET    = 1'b1
) (
    input  logic           CLK,
    input  logic           RST_N,
    cleared_ram_if.slave   bus
);

    localparam int             AW        = ADDRESS_BUS_WIDTH;
    localparam int             MEM_DEPTH = depth_of(AW);
    localparam int             CW        = AW + 1;
    localparam logic [CW-1:0]  LAST      = CW'(MEM_DEPTH - 1);
    localparam state_e         RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    logic [BITS-1:0] mem_q [MEM_DEPTH];

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [BITS-1:0] mem_wdata;
    logic            busy;

    // Sequencer: user writes in IDLE, one zero write per cycle in CLEAR.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = bus.WAddress;
        mem_wdata = bus.D;
        case (state_q)
            IDLE: begin
                mem_we = bus.WE;
                if (bus.CLR) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[AW-1:0];
                mem_wdata = '0;
                if (bus.CLR) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // FSM state and sweep counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array; contents only become defined through writes or the sweep.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign bus.Busy = busy;

    ram_read_port #(.BITS(BITS), .AW(AW)) u_port_a (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Busy     (busy),
        .Addr     (bus.RAddressA),
        .RE       (bus.REA),
        .WE       (bus.WE),
        .WAddress (bus.WAddress),
        .D        (bus.D),
        .Word     (mem_q[bus.RAddressA]),
        .Q        (bus.QA),
        .QValid   (bus.QAValid)
    );

    ram_read_port #(.BITS(BITS), .AW(AW)) u_port_b (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Busy     (busy),
        .Addr     (bus.RAddressB),
        .RE       (bus.REB),
        .WE       (bus.WE),
        .WAddress (bus.WAddress),
        .D        (bus.D),
        .Word     (mem_q[bus.RAddressB]),
        .Q        (bus.QB),
        .QValid   (bus.QBValid)
    );

endmodule

// File: tb/tb_cleared_ram_2r1w.sv
// Bench for cleared_ram_2r1w: vector table, corner sequences and a random run against a model.
module tb_cleared_ram_2r1w;

    localparam int BITS = 8;
    localparam int AW   = 3;
    localparam int MD   = 8;

    logic CLK = 1'b0;
    logic rst1_n;
    logic rst0_n;

    always #5 CLK = ~CLK;

    cleared_ram_if #(.BITS(BITS), .AW(AW)) ifc1 ();
    cleared_ram_if #(.BITS(BITS), .AW(AW)) ifc0 ();

    cleared_ram_2r1w #(.BITS(BITS), .ADDRESS_BUS_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut1 (
        .CLK   (CLK),
        .RST_N (rst1_n),
        .bus   (ifc1)
    );

    cleared_ram_2r1w #(.BITS(BITS), .ADDRESS_BUS_WIDTH(AW), .CLEAR_ON_RESET(1'b0)) dut0 (
        .CLK   (CLK),
        .RST_N (rst0_n),
        .bus   (ifc0)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: array contents, remaining sweep cycles, port outputs.
    logic [7:0] m_mem [MD];
    int         m_left;
    logic [7:0] m_qa, m_qb;
    logic       m_qav, m_qbv;

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] d;
        logic       rea;
        logic [2:0] ra;
        logic       reb;
        logic [2:0] rb;
        logic [7:0] qa;
        logic       qav;
        logic [7:0] qb;
        logic       qbv;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle1();
        ifc1.WE = 0; ifc1.WAddress = 0; ifc1.D = 0;
        ifc1.REA = 0; ifc1.RAddressA = 0; ifc1.REB = 0; ifc1.RAddressB = 0;
        ifc1.CLR = 0;
    endtask

    task automatic idle0();
        ifc0.WE = 0; ifc0.WAddress = 0; ifc0.D = 0;
        ifc0.REA = 0; ifc0.RAddressA = 0; ifc0.REB = 0; ifc0.RAddressB = 0;
        ifc0.CLR = 0;
    endtask

    task automatic model_reset();
        m_left = MD;
        m_qa = 0; m_qb = 0; m_qav = 0; m_qbv = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        if (m_left > 0) begin
            m_mem[MD - m_left] = 8'h00;
            m_qav = 0;
            m_qbv = 0;
            if (ifc1.CLR) m_left = MD;
            else          m_left = m_left - 1;
        end else begin
            m_qav = ifc1.REA;
            m_qbv = ifc1.REB;
            if (ifc1.REA)
                m_qa = (ifc1.WE && ifc1.WAddress == ifc1.RAddressA) ? ifc1.D : m_mem[ifc1.RAddressA];
            if (ifc1.REB)
                m_qb = (ifc1.WE && ifc1.WAddress == ifc1.RAddressB) ? ifc1.D : m_mem[ifc1.RAddressB];
            if (ifc1.WE) m_mem[ifc1.WAddress] = ifc1.D;
            if (ifc1.CLR) m_left = MD;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        check("model_qa",    ifc1.QA,      m_qa);
        check("model_qav",   ifc1.QAValid, m_qav);
        check("model_qb",    ifc1.QB,      m_qb);
        check("model_qbv",   ifc1.QBValid, m_qbv);
        check("model_busy",  ifc1.Busy,    (m_left > 0));
    endtask

    task automatic count_busy(input string name, input int mid_write);
        int bc;
        bc = 0;
        while (ifc1.Busy && bc < 20) begin
            bc++;
            idle1();
            if (bc == mid_write) begin
                ifc1.WE = 1; ifc1.WAddress = 3'd4; ifc1.D = 8'hFF;
                ifc1.REA = 1; ifc1.RAddressA = 3'd4;
            end
            step();
        end
        idle1();
        check(name, bc, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst1_n = 0;
        rst0_n = 0;
        idle1();
        idle0();
        model_reset();

        vecs[0] = '{1, 3'd3, 8'hA5, 0, 3'd0, 0, 3'd0, 8'h00, 0, 8'h00, 0};
        vecs[1] = '{0, 3'd0, 8'h00, 1, 3'd3, 0, 3'd0, 8'hA5, 1, 8'h00, 0};
        vecs[2] = '{0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'hA5, 0, 8'h00, 0};
        vecs[3] = '{1, 3'd5, 8'h3C, 1, 3'd5, 1, 3'd5, 8'h3C, 1, 8'h3C, 1};
        vecs[4] = '{0, 3'd0, 8'h00, 0, 3'd0, 1, 3'd3, 8'h3C, 0, 8'hA5, 1};
        vecs[5] = '{0, 3'd0, 8'h00, 1, 3'd5, 1, 3'd5, 8'h3C, 1, 8'h3C, 1};
        vecs[6] = '{1, 3'd3, 8'h77, 1, 3'd3, 1, 3'd2, 8'h77, 1, 8'h00, 1};

        repeat (2) @(posedge CLK);
        #1;
        check("rst_qa",     ifc1.QA, 0);
        check("rst_qav",    ifc1.QAValid, 0);
        check("rst_qbv",    ifc1.QBValid, 0);
        check("rst_busy1",  ifc1.Busy, 1);
        check("rst_busy0",  ifc0.Busy, 0);
        check("rst_qa0",    ifc0.QA, 0);
        #1;
        rst1_n = 1;

        // Power-up sweep length, then every word reads back zero.
        count_busy("sweep_len_reset", 0);
        for (int i = 0; i < MD; i++) begin
            ifc1.REA = 1; ifc1.RAddressA = 3'(i);
            ifc1.REB = 1; ifc1.RAddressB = 3'(MD - 1 - i);
            step();
            check("clear_qa", ifc1.QA, 8'h00);
            check("clear_qav", ifc1.QAValid, 1);
            check("clear_qb", ifc1.QB, 8'h00);
        end
        idle1();

        // Vector table: read latency, hold, bypass on both ports.
        for (int i = 0; i < 7; i++) begin
            ifc1.WE = vecs[i].we; ifc1.WAddress = vecs[i].wa; ifc1.D = vecs[i].d;
            ifc1.REA = vecs[i].rea; ifc1.RAddressA = vecs[i].ra;
            ifc1.REB = vecs[i].reb; ifc1.RAddressB = vecs[i].rb;
            step();
            check("vec_qa",  ifc1.QA,      vecs[i].qa);
            check("vec_qav", ifc1.QAValid, vecs[i].qav);
            check("vec_qb",  ifc1.QB,      vecs[i].qb);
            check("vec_qbv", ifc1.QBValid, vecs[i].qbv);
        end
        idle1();

        // Clear together with a write; write during the sweep is dropped.
        ifc1.CLR = 1; ifc1.WE = 1; ifc1.WAddress = 3'd2; ifc1.D = 8'h11;
        step();
        count_busy("sweep_len_clr", 4);
        ifc1.REA = 1; ifc1.RAddressA = 3'd2;
        ifc1.REB = 1; ifc1.RAddressB = 3'd4;
        step();
        check("clr_mem2", ifc1.QA, 8'h00);
        check("clr_mem4", ifc1.QB, 8'h00);
        idle1();

        // Reset in the middle of a sweep.
        ifc1.WE = 1; ifc1.WAddress = 3'd3; ifc1.D = 8'h77;
        step();
        idle1();
        ifc1.CLR = 1; ifc1.REA = 1; ifc1.RAddressA = 3'd3;
        step();
        check("pre_rst_qa", ifc1.QA, 8'h77);
        idle1();
        repeat (4) step();
        #2;
        rst1_n = 0;
        #1;
        check("midrst_qa",   ifc1.QA, 0);
        check("midrst_qav",  ifc1.QAValid, 0);
        check("midrst_busy", ifc1.Busy, 1);
        model_reset();
        @(posedge CLK);
        #3;
        rst1_n = 1;
        count_busy("sweep_len_midrst", 0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            ifc1.WE = 1'($urandom_range(0, 1));
            ifc1.WAddress = 3'($urandom_range(0, 7));
            ifc1.D = 8'($urandom);
            ifc1.REA = 1'($urandom_range(0, 1));
            ifc1.RAddressA = 3'($urandom_range(0, 7));
            ifc1.REB = 1'($urandom_range(0, 1));
            ifc1.RAddressB = 3'($urandom_range(0, 7));
            ifc1.CLR = ($urandom_range(0, 39) == 0);
            step();
        end
        idle1();

        // No clear on reset: usable in the first cycle.
        rst0_n = 1;
        #1;
        check("ncr_busy", ifc0.Busy, 0);
        ifc0.WE = 1; ifc0.WAddress = 3'd1; ifc0.D = 8'h5A;
        ifc0.REA = 1; ifc0.RAddressA = 3'd1;
        @(posedge CLK);
        #1;
        check("ncr_qa",   ifc0.QA, 8'h5A);
        check("ncr_qav",  ifc0.QAValid, 1);
        idle0();
        ifc0.REB = 1; ifc0.RAddressB = 3'd1;
        @(posedge CLK);
        #1;
        check("ncr_qb",    ifc0.QB, 8'h5A);
        check("ncr_qbv",   ifc0.QBValid, 1);
        check("ncr_qa_hold", ifc0.QA, 8'h5A);
        check("ncr_qav0",  ifc0.QAValid, 0);
        idle0();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
